apb_completer_regbank: RTL

- APB completer: the peripheral end of the bridge's APB bus; one instance hangs off each Pselx bit.
- Decodes Paddr into a word-indexed register bank, inserts a parameterised number of wait states, and returns Prdata/Pready/Pslverr.
- Used as the bridge's downstream slave model in simulation and as the synthesizable config block in real peripherals.

---
 rtl/apb_completer_pkg.sv | 17 +
 rtl/apb_regfile.sv | 46 ++++
 rtl/apb_completer_regbank.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/apb_completer_pkg.sv
// Shared types and constants for the APB completer register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_completer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int IDX_ID    = 0;
  localparam int IDX_COUNT = 1;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA5B0_0001;

endpackage

// File: rtl/apb_regfile.sv
// Word-indexed register array: one write port, combinational read mux.
// Latency: writes land at the clock edge; reads are combinational.
// Backpressure: none; idx 0 and idx 1 are never written here.
module apb_regfile
  import apb_completer_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter int          IDX_W    = $clog2(NUM_REGS),
  parameter logic [31:0] ID_VALUE = DEFAULT_ID_VALUE
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [31:0]      wr_dat_i,
  input  logic [31:0]      count_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [31:0]      rd_dat_o
);

  logic [31:0] regs_q [NUM_REGS];

  // Storage for the read/write registers; ID and counter slots are never written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i && (int'(wr_idx_i) > IDX_COUNT) && (int'(wr_idx_i) < NUM_REGS)) begin
      regs_q[wr_idx_i] <= wr_dat_i;
    end
  end

  // Read mux: idx 0 is the hardwired ID, idx 1 is the live transfer counter.
  always_comb begin
    rd_dat_o = '0;
    if (int'(rd_idx_i) == IDX_ID) begin
      rd_dat_o = ID_VALUE;
    end else if (int'(rd_idx_i) == IDX_COUNT) begin
      rd_dat_o = count_i;
    end else if (int'(rd_idx_i) < NUM_REGS) begin
      rd_dat_o = regs_q[rd_idx_i];
    end
  end

endmodule

// File: rtl/apb_completer_regbank.sv
// APB completer: decodes Paddr into a register bank with an ID and a transfer counter.
// Latency: setup + WAIT_CYCLES + 1 access cycles; Pready high for exactly one cycle.
// Backpressure: Pready held low for WAIT_CYCLES access cycles; dropping Psel aborts.
module apb_completer_regbank
  import apb_completer_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic [31:0] xfer_count
);

  localparam int               IDX_W      = $clog2(NUM_REGS);
  localparam logic [IDX_W:0]   NUM_REGS_W = (IDX_W+1)'(NUM_REGS);
  localparam logic [3:0]       WAIT_LD    = 4'(WAIT_CYCLES);

  state_e             state_q, state_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdat_q, wdat_d;
  logic               err_q, err_d;
  logic [31:0]        prdata_q, prdata_d;
  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;
  logic [31:0]        count_q, count_d;

  logic               setup;
  logic               complete;
  logic [IDX_W-1:0]   live_idx;
  logic               live_err;
  logic               req_wr;
  logic [IDX_W-1:0]   req_idx;
  logic [31:0]        req_wdat;
  logic               req_err;
  logic               rf_wr_en;
  logic [31:0]        rf_rd_dat;
  logic               unused_paddr_hi;

  // Address bits above the index are ignored, so the bank aliases through the space.
  assign unused_paddr_hi = ^Paddr[31:IDX_W+2];
  assign live_idx        = Paddr[IDX_W+1:2];
  assign live_err        = (Paddr[1:0] != 2'b00)
                        || ({1'b0, live_idx} >= NUM_REGS_W)
                        || (Pwrite && (int'(live_idx) <= IDX_COUNT));
  assign setup           = Psel && !Penable;

  // Completion from IDLE/DONE happens only with zero wait states, on the live setup
  // values; completion from WAIT always uses what was latched at setup.
  assign req_wr   = (state_q == ST_WAIT) ? wr_q   : Pwrite;
  assign req_idx  = (state_q == ST_WAIT) ? idx_q  : live_idx;
  assign req_wdat = (state_q == ST_WAIT) ? wdat_q : Pwdata;
  assign req_err  = (state_q == ST_WAIT) ? err_q  : live_err;

  apb_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk_i    (Hclk),
    .rst_ni   (Hresetn),
    .wr_en_i  (rf_wr_en),
    .wr_idx_i (req_idx),
    .wr_dat_i (req_wdat),
    .count_i  (count_q),
    .rd_idx_i (req_idx),
    .rd_dat_o (rf_rd_dat)
  );

  // Next-state, request latching and registered-output computation.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdat_d    = wdat_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    count_d   = count_q;
    rf_wr_en  = 1'b0;
    complete  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Access strobe without a preceding setup is ignored here.
        state_d = ST_IDLE;
        if (setup) begin
          wr_d   = Pwrite;
          idx_d  = live_idx;
          wdat_d = Pwdata;
          err_d  = live_err;
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
            state_d  = ST_DONE;
          end else begin
            wcnt_d  = WAIT_LD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!Psel) begin
          state_d = ST_IDLE;
        end else if (Penable) begin
          if (wcnt_q == 4'd1) begin
            complete = 1'b1;
            state_d  = ST_DONE;
          end else begin
            wcnt_d = wcnt_q - 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete) begin
      pready_d  = 1'b1;
      pslverr_d = req_err;
      if (!req_err) begin
        // A read of idx 1 returns the count before this transfer's increment.
        count_d = count_q + 32'd1;
        if (req_wr) begin
          rf_wr_en = 1'b1;
        end else begin
          prdata_d = rf_rd_dat;
        end
      end
    end
  end

  // State, latched request and output registers.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      wdat_q    <= '0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      wdat_q    <= wdat_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      count_q   <= count_d;
    end
  end

  assign Prdata     = prdata_q;
  assign Pready     = pready_q;
  assign Pslverr    = pslverr_q;
  assign xfer_count = count_q;

endmodule
